// File: rtl/gsm_lpc_analysis_div_seq.sv
// Sequential Q15 fractional divider: 15-step restoring division of num/denum (0 <= num <= denum).
// Handshake: ap_start sampled in IDLE, ap_done/ap_ready pulse for one cycle with a registered result.
module gsm_lpc_analysis_div_seq #(
    parameter logic [31:0] ID        = 32'd1,
    parameter logic [31:0] NUM_STAGE = 32'd16
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               ap_start,
    input  logic signed [15:0] num,
    input  logic signed [15:0] denum,
    output logic               ap_idle,
    output logic               ap_done,
    output logic               ap_ready,
    output logic signed [15:0] ap_return,
    output logic               ap_err
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [16:0] rem;
    logic [15:0] dvs;
    logic [15:0] quot;
    logic [16:0] rem_nxt;
    logic [15:0] quot_nxt;
    logic        bad_op;
    logic        zero_op;
    logic        last_step;

    // One restoring step; remainder stays below divisor, so the 17-bit shift cannot overflow.
    function automatic logic [32:0] restore_step(input logic [16:0] r,
                                                 input logic [15:0] d,
                                                 input logic [15:0] q);
        logic [16:0] r2;
        r2 = r << 1;
        if (r2 >= {1'b0, d})
            restore_step = {r2 - {1'b0, d}, (q << 1) | 16'd1};
        else
            restore_step = {r2, q << 1};
    endfunction

    assign bad_op    = (num < 16'sd0) || (denum <= 16'sd0) || (num > denum);
    assign zero_op   = (num == 16'sd0);
    assign last_step = (cnt == 4'd14);
    assign {rem_nxt, quot_nxt} = restore_step(rem, dvs, quot);

    always_comb begin
        state_nxt = state;
        ap_idle   = 1'b0;
        ap_done   = 1'b0;
        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start)
                    state_nxt = (bad_op || zero_op) ? DONE : CALC;
            end
            CALC: begin
                if (last_step)
                    state_nxt = DONE;
            end
            DONE: begin
                ap_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ap_ready = ap_done;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            ap_return <= 16'sd0;
            ap_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (ap_start && (bad_op || zero_op)) begin
                        ap_return <= 16'sd0;
                        ap_err    <= bad_op;
                    end
                end
                CALC: begin
                    cnt <= cnt + 4'd1;
                    if (last_step) begin
                        ap_return <= $signed(quot_nxt & 16'h7fff);
                        ap_err    <= 1'b0;
                    end
                end
                default: cnt <= 4'd0;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always reloaded on acceptance.
    always_ff @(posedge ap_clk) begin
        if (state == IDLE && ap_start) begin
            rem  <= {1'b0, num};
            dvs  <= denum;
            quot <= 16'd0;
        end else if (state == CALC) begin
            rem  <= rem_nxt;
            quot <= quot_nxt;
        end
    end

endmodule

// File: tb/tb_gsm_lpc_analysis_div_seq.sv
// Bench for gsm_lpc_analysis_div_seq: randomized and directed divisions scored against an arithmetic model.
module tb_gsm_lpc_analysis_div_seq;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ap_start = 1'b0;
    logic signed [15:0] num = 16'sd0;
    logic signed [15:0] denum = 16'sd0;
    logic               ap_idle, ap_done, ap_ready, ap_err;
    logic signed [15:0] ap_return;

    gsm_lpc_analysis_div_seq #(.ID(32'd1), .NUM_STAGE(32'd16)) dut (
        .ap_clk(clk), .ap_rst(rst), .ap_start(ap_start), .num(num), .denum(denum),
        .ap_idle(ap_idle), .ap_done(ap_done), .ap_ready(ap_ready),
        .ap_return(ap_return), .ap_err(ap_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int ret; int err; int cyc; } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: Q15 fraction num/denum truncated, saturating exactly at 1.0.
    function automatic void model(input int n, input int d, output int ret, output int err,
                                  output bit fast);
        if (n < 0 || d <= 0 || n > d) begin
            ret = 0; err = 1; fast = 1;
        end else if (n == 0) begin
            ret = 0; err = 0; fast = 1;
        end else begin
            err = 0; fast = 0;
            ret = (n == d) ? 32767 : int'((longint'(n) * 32768) / longint'(d));
        end
    endfunction

    // Monitor: pops an expectation on every ap_done and checks the hold cycle that follows.
    bit hold_pend = 0;
    int hold_ret, hold_err;
    always @(negedge clk) begin
        exp_t e;
        if (hold_pend) begin
            hold_pend = 0;
            chk("idle_after_done", int'(ap_idle), 1);
            chk("hold_return", int'(ap_return), hold_ret);
            chk("hold_err", int'(ap_err), hold_err);
        end
        if (ap_done) begin
            chk("ready_eq_done", int'(ap_ready), 1);
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("return", int'(ap_return), e.ret);
                chk("err", int'(ap_err), e.err);
                chk("done_cycle", cyc, e.cyc);
                hold_pend = 1;
                hold_ret  = e.ret;
                hold_err  = e.err;
            end
        end
    end

    task automatic push_exp(input int n, input int d, input int accept_edge);
        exp_t e;
        int r, er;
        bit f;
        model(n, d, r, er, f);
        e.ret = r; e.err = er;
        e.cyc = f ? accept_edge : accept_edge + 15;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge while the DUT is idle; the start is accepted at the next edge.
    task automatic do_op(input int n, input int d);
        push_exp(n, d, cyc + 1);
        num = 16'(n); denum = 16'(d); ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        num = 16'($urandom); denum = 16'($urandom);
        wait_drain();
    endtask

    int dn[12] = '{1, 1000, 1, 0, 3, -1, 0, 32767, 1, 32766, -32768, 5};
    int dd[12] = '{2, 1000, 3, 5, 2, 4, 0, 32767, 32767, 32767, -1, 7};

    initial begin
        int n, d, a;
        logic [15:0] t;
        repeat (3) @(negedge clk);
        chk("rst_idle", int'(ap_idle), 1);
        chk("rst_done", int'(ap_done), 0);
        chk("rst_ready", int'(ap_ready), 0);
        chk("rst_return", int'(ap_return), 0);
        chk("rst_err", int'(ap_err), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) do_op(dn[i], dd[i]);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                t = 16'($urandom); n = int'($signed(t));
                t = 16'($urandom); d = int'($signed(t));
            end else begin
                d = int'($urandom_range(1, 32767));
                n = int'($urandom_range(0, d));
            end
            do_op(n, d);
        end

        // ap_start held high; operands scrambled mid-calculation.
        a = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            d = int'($urandom_range(2, 32767));
            n = int'($urandom_range(1, d));
            num = 16'(n); denum = 16'(d); ap_start = 1'b1;
            push_exp(n, d, a);
            while (cyc < a + 7) @(negedge clk);
            num = 16'($urandom); denum = 16'($urandom);
            while (cyc < a + 16) @(negedge clk);
            a = a + 17;
        end
        ap_start = 1'b0;
        wait_drain();

        // Reset aborts an in-flight 1/2; the aborted operation must not signal done.
        a = cyc + 1;
        num = 16'sd1; denum = 16'sd2; ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        while (cyc < a + 7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_idle", int'(ap_idle), 1);
        chk("abort_done", int'(ap_done), 0);
        chk("abort_return", int'(ap_return), 0);
        chk("abort_err", int'(ap_err), 0);
        repeat (20) @(negedge clk);
        do_op(1, 4);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gsm_lpc_analysis_div_seq.md
GSM_LPC_ANALYSIS_DIV_SEQ -- requirements
Module: gsm_lpc_analysis_div_seq

Interface
REQ-001 SHALL provide parameter ID, default 32'd1, instance identifier with no functional effect.
REQ-002 SHALL provide parameter NUM_STAGE, default 32'd16, nominal start-to-done latency in cycles; informational only.
REQ-003 SHALL provide port ap_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port ap_rst, input, 1, synchronous active-high reset.
REQ-005 SHALL provide port ap_start, input, 1, request; sampled only in IDLE.
REQ-006 SHALL provide port num, input, 16, signed dividend; captured when a start is accepted.
REQ-007 SHALL provide port denum, input, 16, signed divisor; captured when a start is accepted.
REQ-008 SHALL provide port ap_idle, output, 1, high while in IDLE.
REQ-009 SHALL provide port ap_done, output, 1, one-cycle pulse marking a valid result.
REQ-010 SHALL provide port ap_ready, output, 1, equal to ap_done (inputs are free for reuse).
REQ-011 SHALL provide port ap_return, output, 16, signed Q15 quotient.
REQ-012 SHALL provide port ap_err, output, 1, precondition-violation flag, qualified by ap_done.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 SHALL accept a start only in IDLE with ap_start=1; ap_start SHALL be ignored in CALC and DONE.
REQ-015 SHALL treat num<0, denum<=0 or num>denum as an error.
  - On error, transition IDLE->DONE.
  - In DONE: ap_return=0, ap_err=1.
REQ-016 SHALL treat valid num==0 as a fast path.
  - Transition IDLE->DONE.
  - In DONE: ap_return=0, ap_err=0.
REQ-017 SHALL handle any other accepted start as follows.
  - Load remainder=num (17-bit unsigned), divisor=denum, quotient=0, 4-bit iteration counter=0.
  - Transition to CALC.
REQ-018 SHALL perform exactly one restoring step per CALC cycle.
  - rem2 = remainder<<1.
  - If rem2>=divisor: remainder=rem2-divisor and quotient=(quotient<<1)|1.
  - Otherwise: remainder=rem2 and quotient=quotient<<1.
REQ-019 SHALL execute exactly 15 CALC cycles, then go to DONE.
  - Start accepted at edge T: CALC cycles T+1..T+15, DONE at T+16.
  - ap_done high for the single cycle T+16.
REQ-020 SHALL produce quotient = floor(num*32768/denum), range 0..32767; num==denum SHALL give 32767.
REQ-021 SHALL size compare/subtract at 17 bits so remainder<<1 never overflows.
REQ-022 SHALL take result bit 15 (sign) of ap_return as always 0.
REQ-023 SHALL return DONE->IDLE unconditionally on the next edge.
  - ap_start high in DONE is not accepted; it is accepted only once IDLE is re-entered.
REQ-024 SHALL register ap_return and ap_err in DONE and hold them until the next DONE, including across IDLE.
REQ-025 SHALL drive ap_idle=1 only in IDLE; ap_done=ap_ready=1 only in DONE.
REQ-026 SHALL not alter in-flight computation if num/denum change during CALC (operands are captured at acceptance).

Reset
REQ-027 SHALL, with ap_rst=1 at a rising edge, set in the following cycle: state=IDLE, ap_idle=1, ap_done=0, ap_ready=0, ap_return=0, ap_err=0, counter=0.
REQ-028 SHALL abort any CALC or DONE activity on reset.
  - No ap_done pulse for the aborted operation.
  - A start after reset deasserts is processed normally.
REQ-029 SHALL give ap_rst priority over ap_start in the same cycle.

Verification
REQ-030 SHALL cover: num=1, denum=2 -> ap_done at T+16, ap_return=16384, ap_err=0, ap_idle=1 at T+17.
REQ-031 SHALL cover: num=1000, denum=1000 -> ap_return=32767 at T+16; num=1, denum=3 -> 10922.
REQ-032 SHALL cover: num=0, denum=5 -> ap_done at T+1, ap_return=0, ap_err=0.
REQ-033 SHALL cover errors (num=3, denum=2; num=-1, denum=4; num=0, denum=0) -> ap_done at T+1, ap_return=0, ap_err=1.
REQ-034 SHALL cover: ap_start held high continuously with operands changed mid-CALC.
  - Back-to-back results are 17 cycles apart.
  - Each result matches the operands captured at its own acceptance.
REQ-035 SHALL cover: ap_rst pulsed at T+8 during CALC (num=1, denum=2).
  - No ap_done; ap_return=0; ap_idle=1 next cycle.
  - A subsequent start (num=1, denum=4) yields 8192.
